// File: rtl/fft_bitrev_reorder.sv
// Output reorder buffer for the 32-point SDF FFT.
// Frames arrive in bit-reversed bin order. Each frame is written into one half
// of a ping-pong buffer, using the bit-reversed sample count as the address.
// The completed half is then read linearly, which replays the frame in natural
// bin order as a gap-free 32-cycle burst.
module fft_bitrev_reorder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [21:0] data_real_in,
    input  logic [21:0] data_imag_in,
    output logic        out_valid,
    output logic [21:0] data_real_out,
    output logic [21:0] data_imag_out,
    output logic [4:0]  out_index,
    output logic        frame_done
);

    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int W     = 22;

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    typedef enum logic [0:0] {
        RD_IDLE,
        RD_BURST
    } rd_state_t;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [LOG2N-1:0] wr_cnt_reg;
    logic [LOG2N-1:0] wr_addr;
    logic             wr_bank_reg;
    logic             wr_en;
    logic             frame_ready;

    // Both banks share one array: the bank select is the address MSB, so
    // the storage maps onto a single simple dual-port block RAM.
    logic [2*W-1:0]   mem [0:2*N-1];

    genvar gi;
    generate
        for (gi = 0; gi < LOG2N; gi++) begin : g_bitrev
            assign wr_addr[gi] = wr_cnt_reg[LOG2N-1-gi];
        end
    endgenerate

    // Samples that coincide with reset are dropped.
    assign wr_en       = in_valid && !rst;
    assign frame_ready = wr_en && (wr_cnt_reg == LAST_IDX);

    // Write counter and bank pointer; bank flips as each frame completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_reg  <= '0;
            wr_bank_reg <= 1'b0;
        end else if (wr_en) begin
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
            if (wr_cnt_reg == LAST_IDX) begin
                wr_bank_reg <= !wr_bank_reg;
            end
        end
    end

    // Store the sample at its natural-order slot in the write bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_reg, wr_addr}] <= {data_real_in, data_imag_in};
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rd_state_t        state_reg;
    rd_state_t        state_next;
    logic [LOG2N-1:0] rd_cnt_reg;
    logic [LOG2N-1:0] rd_cnt_next;
    logic             rd_bank_reg;
    logic             rd_bank_next;
    logic             rd_en;
    logic [LOG2N:0]   rd_addr;

    assign rd_addr = {rd_bank_reg, rd_cnt_reg};

    // Read FSM register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= RD_IDLE;
            rd_cnt_reg  <= '0;
            rd_bank_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rd_cnt_reg  <= rd_cnt_next;
            rd_bank_reg <= rd_bank_next;
        end
    end

    // Next-state logic: start a burst on a completed frame, and chain the
    // next burst directly when a frame completes on the last read cycle.
    always_comb begin
        state_next   = state_reg;
        rd_cnt_next  = rd_cnt_reg;
        rd_bank_next = rd_bank_reg;
        rd_en        = 1'b0;
        case (state_reg)
            RD_IDLE: begin
                if (frame_ready) begin
                    state_next   = RD_BURST;
                    rd_bank_next = wr_bank_reg;
                    rd_cnt_next  = '0;
                end
            end
            RD_BURST: begin
                rd_en = 1'b1;
                if (rd_cnt_reg == LAST_IDX) begin
                    rd_cnt_next = '0;
                    if (frame_ready) begin
                        rd_bank_next = wr_bank_reg;
                    end else begin
                        state_next = RD_IDLE;
                    end
                end else begin
                    rd_cnt_next = rd_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = RD_IDLE;
            end
        endcase
    end

    // Registered outputs; the RAM read lands directly in the output register,
    // which is cleared whenever no burst is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            frame_done    <= 1'b0;
            out_index     <= '0;
            data_real_out <= '0;
            data_imag_out <= '0;
        end else begin
            out_valid  <= rd_en;
            frame_done <= rd_en && (rd_cnt_reg == LAST_IDX);
            out_index  <= rd_en ? rd_cnt_reg : '0;
            if (rd_en) begin
                {data_real_out, data_imag_out} <= mem[rd_addr];
            end else begin
                data_real_out <= '0;
                data_imag_out <= '0;
            end
        end
    end

    // A frame completing mid-burst would overwrite the bank being read.
    a_no_overrun : assert property (@(posedge clk) disable iff (rst)
        !(frame_ready && (state_reg == RD_BURST) && (rd_cnt_reg != LAST_IDX)));

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Testbench for fft_bitrev_reorder. A scoreboard receives the 32 expected
// natural-order outputs, each tagged with the cycle it must appear in, as soon
// as the last sample of a frame is driven. Every cycle the DUT outputs are
// compared against the head of the queue, or against all-zero when nothing is due.
module tb_fft_bitrev_reorder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [21:0] data_real_in;
    logic [21:0] data_imag_in;
    logic        out_valid;
    logic [21:0] data_real_out;
    logic [21:0] data_imag_out;
    logic [4:0]  out_index;
    logic        frame_done;

    fft_bitrev_reorder dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .data_real_in  (data_real_in),
        .data_imag_in  (data_imag_in),
        .out_valid     (out_valid),
        .data_real_out (data_real_out),
        .data_imag_out (data_imag_out),
        .out_index     (out_index),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [50:0] vec;  // {valid, done, index[4:0], real[21:0], imag[21:0]}
    } exp_t;

    exp_t        sb_q[$];
    int          cyc;
    int          tests_run;
    int          tests_failed;
    int          m_cnt;
    logic [21:0] m_re [0:31];
    logic [21:0] m_im [0:31];
    logic [50:0] exp_vec;
    logic [50:0] obs_vec;

    function automatic logic [4:0] bitrev5(input logic [4:0] b);
        return {b[0], b[1], b[2], b[3], b[4]};
    endfunction

    // Reference model of the input side: collect samples in arrival order;
    // bin k of the completed frame is arrival position bitrev5(k).
    task automatic model_input(input logic r, input logic v,
                               input logic [21:0] re, input logic [21:0] im);
        exp_t e;
        logic [4:0] k5;
        if (r) begin
            sb_q.delete();
            m_cnt = 0;
        end else if (v) begin
            m_re[m_cnt] = re;
            m_im[m_cnt] = im;
            if (m_cnt == 31) begin
                // Sampled at edge cyc+1, X[k] visible after edge cyc+2+k.
                for (int k = 0; k < 32; k++) begin
                    k5    = 5'(k);
                    e.cyc = cyc + 2 + k;
                    e.vec = {1'b1, (k == 31), k5,
                             m_re[bitrev5(k5)], m_im[bitrev5(k5)]};
                    sb_q.push_back(e);
                end
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    // Drive one cycle of stimulus, update the model, advance past the edge.
    task automatic drive_cycle(input logic r, input logic v,
                               input int re, input int im);
        rst          = r;
        in_valid     = v;
        data_real_in = 22'(re);
        data_imag_in = 22'(im);
        model_input(r, v, data_real_in, data_imag_in);
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    // Expected output vector for the current cycle (pops the scoreboard).
    task automatic model_next(output logic [50:0] v);
        v = '0;
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            v = sb_q[0].vec;
            void'(sb_q.pop_front());
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 53; i++) begin
            if (i < 3) drive_cycle(1'b1, 1'b1, int'($urandom()), int'($urandom()));
            else       drive_cycle(1'b0, 1'b0, 0, 0);
            model_next(exp_vec);
            obs_vec = {out_valid, frame_done, out_index, data_real_out, data_imag_out};
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 72; i++) begin
            if (i < 32) drive_cycle(1'b0, 1'b1, i, -i);
            else        drive_cycle(1'b0, 1'b0, 0, 0);
            model_next(exp_vec);
            obs_vec = {out_valid, frame_done, out_index, data_real_out, data_imag_out};
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL ramp cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_back_to_back();
        int v;
        for (int i = 0; i < 136; i++) begin
            v = (i % 32) + 100 * (i / 32);
            if (i < 96) drive_cycle(1'b0, 1'b1, v, -v);
            else        drive_cycle(1'b0, 1'b0, 0, 0);
            model_next(exp_vec);
            obs_vec = {out_valid, frame_done, out_index, data_real_out, data_imag_out};
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_gapped();
        int s;
        for (int i = 0; i < 136; i++) begin
            s = i / 3;
            if (i < 96 && (i % 3) == 0) drive_cycle(1'b0, 1'b1, 1000 + s, -2000 + 5 * s);
            else                        drive_cycle(1'b0, 1'b0, int'($urandom()), 0);
            model_next(exp_vec);
            obs_vec = {out_valid, frame_done, out_index, data_real_out, data_imag_out};
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL gapped cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 93; i++) begin
            if (i < 20)       drive_cycle(1'b0, 1'b1, 500 + i, 600 + i);
            else if (i == 20) drive_cycle(1'b1, 1'b1, 999, 999);
            else if (i < 53)  drive_cycle(1'b0, 1'b1, 300 + (i - 21), -(i - 21) - 7);
            else              drive_cycle(1'b0, 1'b0, 0, 0);
            model_next(exp_vec);
            obs_vec = {out_valid, frame_done, out_index, data_real_out, data_imag_out};
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL reset_mid_frame cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        // Last sample at iteration 31; X[10] visible after iteration 42;
        // reset is applied at the following edge.
        for (int i = 0; i < 84; i++) begin
            if (i < 32)       drive_cycle(1'b0, 1'b1, 40 + 3 * i, 11 - i);
            else if (i == 43) drive_cycle(1'b1, 1'b0, 0, 0);
            else              drive_cycle(1'b0, 1'b0, 0, 0);
            model_next(exp_vec);
            obs_vec = {out_valid, frame_done, out_index, data_real_out, data_imag_out};
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL reset_mid_burst cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < 72; i++) begin
            if (i < 32) drive_cycle(1'b0, 1'b1,
                                    (i % 2) ? 2097151 : -2097152,
                                    (i % 2) ? -2097152 : 2097151);
            else        drive_cycle(1'b0, 1'b0, 0, 0);
            model_next(exp_vec);
            obs_vec = {out_valid, frame_done, out_index, data_real_out, data_imag_out};
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL extremes cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        cyc          = 0;
        tests_run    = 0;
        tests_failed = 0;
        m_cnt        = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        data_real_in = '0;
        data_imag_in = '0;

        test_reset();
        test_ramp();
        test_back_to_back();
        test_gapped();
        test_reset_mid_frame();
        test_reset_mid_burst();
        test_extremes();

        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
